// File: rtl/grid_led.sv
// 6x6 memory-game LED grid: ORs four one-hot index decodes into a registered LED vector.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module grid_led #(
    parameter int NUM_LEDS   = 36,
    parameter int IDX_W      = 6,
    parameter int BLINK_HALF = 25000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [IDX_W-1:0]    mem6x6,
    input  logic [IDX_W-1:0]    card1,
    input  logic [IDX_W-1:0]    card2,
    input  logic [IDX_W-1:0]    selectedCard,
    output logic [NUM_LEDS-1:0] LEDs
);

    // Indices at or above NUM_LEDS match no bit, so they decode to zero.
    function automatic logic [NUM_LEDS-1:0] dec(input logic [IDX_W-1:0] idx);
        logic [NUM_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    logic [NUM_LEDS-1:0] r_leds;
    logic [NUM_LEDS-1:0] w_cursor;
    logic [NUM_LEDS-1:0] w_fixed;
    logic [NUM_LEDS-1:0] w_next;
    logic                w_phase;

`ifdef CURSOR_BLINK_EN
    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == CW'(BLINK_HALF - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_phase = r_phase;
`else
    assign w_phase = (BLINK_HALF >= 1);
`endif

    // A cursor sitting on a card stays lit through the card's own term.
    assign w_cursor = dec(mem6x6) & {NUM_LEDS{w_phase}};
    assign w_fixed  = dec(card1) | dec(card2) | dec(selectedCard);
    assign w_next   = w_cursor | w_fixed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_next;
        end
    end

    assign LEDs = r_leds;

endmodule

// File: tb/tb_grid_led.sv
// Scoreboard bench for grid_led: driver pushes expected LED vectors,
// monitor pops and compares one cycle later.
module tb_grid_led;

    logic        clock;
    logic        reset_n;
    logic [5:0]  mem6x6;
    logic [5:0]  card1;
    logic [5:0]  card2;
    logic [5:0]  selectedCard;
    logic [35:0] LEDs;

    logic [35:0] sb[$];
    int          n_checks;
    int          n_fail;

    grid_led dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mem6x6       (mem6x6),
        .card1        (card1),
        .card2        (card2),
        .selectedCard (selectedCard),
        .LEDs         (LEDs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [35:0] bit1(input int n);
        logic [35:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] exp);
        n_checks++;
        if (LEDs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, LEDs, exp);
        end
    endtask

    task automatic apply(input logic [5:0] m, input logic [5:0] c1,
                         input logic [5:0] c2, input logic [5:0] s,
                         input logic [35:0] exp);
        @(negedge clock);
        mem6x6       = m;
        card1        = c1;
        card2        = c2;
        selectedCard = s;
        sb.push_back(exp);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clock) begin
        logic [35:0] e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pipe", e);
        end
    end

    initial begin
        int sweep[5];
        sweep = '{0, 7, 20, 35, 18};
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        mem6x6 = 6'd3; card1 = 6'd4; card2 = 6'd5; selectedCard = 6'd6;
        #1;
        check("reset_imm", 36'h0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold", 36'h0);

        @(negedge clock);
        reset_n = 1'b1;
        mem6x6 = 6'd5; card1 = 6'd63; card2 = 6'd63; selectedCard = 6'd63;
        sb.push_back(bit1(5));

        foreach (sweep[i]) apply(6'(sweep[i]), 63, 63, 63, bit1(sweep[i]));

        apply(33, 33, 32, 63, bit1(33) | bit1(32));
        apply(32, 33, 32, 63, bit1(33) | bit1(32));
        apply(10, 33, 32, 63, bit1(33) | bit1(32) | bit1(10));
        apply(0, 33, 32, 0, bit1(0) | bit1(32) | bit1(33));
        apply(36, 36, 36, 36, 36'h0);
        apply(63, 63, 63, 63, 36'h0);
        apply(36, 63, 40, 50, 36'h0);
        apply(17, 17, 17, 17, bit1(17));
        apply(35, 0, 63, 36, bit1(35) | bit1(0));
        apply(1, 2, 3, 4, bit1(1) | bit1(2) | bit1(3) | bit1(4));
        drain();

        // Async reset between edges with four LEDs lit
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", 36'h0);
        @(posedge clock);
        #1;
        check("reset_held", 36'h0);
        @(negedge clock);
        reset_n = 1'b1;
        mem6x6 = 6'd12; card1 = 6'd63; card2 = 6'd63; selectedCard = 6'd63;
        sb.push_back(bit1(12));
        apply(9, 8, 63, 7, bit1(9) | bit1(8) | bit1(7));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
